// File: rtl/prbs5_checker.sv
// prbs5_checker: receive-side checker for the 5-bit LFSR generator.
// Locks onto the incoming state words, flywheels through errors once
// locked, counts mispredicted words and flags the illegal all-zero word.
module prbs5_checker #(
  parameter int LOCK_COUNT  = 3,
  parameter int UNLOCK_ERRS = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [4:0]       data_in,
  input  logic             clear_cnt,
  output logic             locked,
  output logic             error,
  output logic             zero_det,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam logic [3:0]       LOCK_THR   = 4'(LOCK_COUNT);
  localparam logic [3:0]       UNLOCK_THR = 4'(UNLOCK_ERRS);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  logic [1:0]       state_q,    state_d;
  logic [4:0]       exp_q,      exp_d;
  logic [3:0]       matchCnt_q, matchCnt_d;
  logic [3:0]       badRun_q,   badRun_d;
  logic             error_q,    error_d;
  logic             zeroDet_q,  zeroDet_d;
  logic             locked_q,   locked_d;
  logic [CNT_W-1:0] errCnt_q,   errCnt_d;
  logic             errInc;

  // Successor of a generator state word (x^5 + x^3 + 1, period 31).
  function automatic logic [4:0] prbsNext(input logic [4:0] s);
    return {s[3:0], s[4] ^ s[2]};
  endfunction

  // Sequence tracking FSM: search for a seed, verify it, then flywheel while locked.
  always_comb begin
    state_d    = state_q;
    exp_d      = exp_q;
    matchCnt_d = matchCnt_q;
    badRun_d   = badRun_q;
    error_d    = 1'b0;
    zeroDet_d  = 1'b0;
    errInc     = 1'b0;
    if (valid_in) begin
      zeroDet_d = (data_in == 5'd0);
      case (state_q)
        ST_SEARCH: begin
          if (data_in != 5'd0) begin
            exp_d      = prbsNext(data_in);
            matchCnt_d = 4'd0;
            state_d    = ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          if (data_in == 5'd0) begin
            matchCnt_d = 4'd0;
            state_d    = ST_SEARCH;
          end else if (data_in == exp_q) begin
            exp_d      = prbsNext(data_in);
            matchCnt_d = matchCnt_q + 4'd1;
            if (matchCnt_q + 4'd1 == LOCK_THR) begin
              badRun_d = 4'd0;
              state_d  = ST_LOCKED;
            end
          end else begin
            exp_d      = prbsNext(data_in);
            matchCnt_d = 4'd0;
          end
        end
        ST_LOCKED: begin
          exp_d = prbsNext(exp_q);
          if (data_in == exp_q) begin
            badRun_d = 4'd0;
          end else begin
            error_d  = 1'b1;
            errInc   = 1'b1;
            badRun_d = badRun_q + 4'd1;
            if (badRun_q + 4'd1 == UNLOCK_THR) begin
              matchCnt_d = 4'd0;
              state_d    = ST_SEARCH;
            end
          end
        end
        default: begin
          state_d = ST_SEARCH;
        end
      endcase
    end
    locked_d = (state_d == ST_LOCKED);
  end

  // Saturating error counter; a clear request overrides a same-cycle increment.
  always_comb begin
    errCnt_d = errCnt_q;
    if (clear_cnt) begin
      errCnt_d = '0;
    end else if (errInc && (errCnt_q != CNT_MAX)) begin
      errCnt_d = errCnt_q + 1'b1;
    end
  end

  // State and registered outputs, cleared immediately by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_SEARCH;
      exp_q      <= 5'd0;
      matchCnt_q <= 4'd0;
      badRun_q   <= 4'd0;
      error_q    <= 1'b0;
      zeroDet_q  <= 1'b0;
      locked_q   <= 1'b0;
      errCnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      exp_q      <= exp_d;
      matchCnt_q <= matchCnt_d;
      badRun_q   <= badRun_d;
      error_q    <= error_d;
      zeroDet_q  <= zeroDet_d;
      locked_q   <= locked_d;
      errCnt_q   <= errCnt_d;
    end
  end

  assign locked   = locked_q;
  assign error    = error_q;
  assign zero_det = zeroDet_q;
  assign err_cnt  = errCnt_q;

endmodule

// File: tb/tb_prbs5_checker.sv
// tb_prbs5_checker: randomized and directed stimulus for prbs5_checker,
// compared every cycle against a position-in-sequence reference model.
module tb_prbs5_checker;

  localparam int LOCK_COUNT  = 3;
  localparam int UNLOCK_ERRS = 4;
  localparam int CNT_W       = 8;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic             validIn;
  logic [4:0]       dataIn;
  logic             clearCnt;
  logic             locked;
  logic             error;
  logic             zeroDet;
  logic [CNT_W-1:0] errCnt;

  int nChecks;
  int nFails;

  // Reference model: sequence table and tracker expressed as sequence positions.
  int seqTab [31];
  int mMode;
  int mExpIdx;
  int mMatch;
  int mBad;
  int mCnt;
  int mErr;
  int mZero;
  int genIdx;

  prbs5_checker #(
    .LOCK_COUNT (LOCK_COUNT),
    .UNLOCK_ERRS(UNLOCK_ERRS),
    .CNT_W      (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .valid_in (validIn),
    .data_in  (dataIn),
    .clear_cnt(clearCnt),
    .locked   (locked),
    .error    (error),
    .zero_det (zeroDet),
    .err_cnt  (errCnt)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nChecks++;
    if (observed !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int posOf(input int d);
    for (int i = 0; i < 31; i++) begin
      if (seqTab[i] == d) return i;
    end
    return -1;
  endfunction

  task automatic modelReset();
    mMode   = 0;
    mExpIdx = 0;
    mMatch  = 0;
    mBad    = 0;
    mCnt    = 0;
    mErr    = 0;
    mZero   = 0;
  endtask

  // One clock of the reference model: mode 0 = searching, 1 = verifying, 2 = locked.
  task automatic modelStep(input bit v, input int d, input bit clr);
    mErr  = 0;
    mZero = 0;
    if (v) begin
      if (d == 0) mZero = 1;
      if (mMode == 0) begin
        if (d != 0) begin
          mExpIdx = (posOf(d) + 1) % 31;
          mMatch  = 0;
          mMode   = 1;
        end
      end else if (mMode == 1) begin
        if (d == 0) begin
          mMode = 0;
        end else if (d == seqTab[mExpIdx]) begin
          mExpIdx = (mExpIdx + 1) % 31;
          mMatch  = mMatch + 1;
          if (mMatch == LOCK_COUNT) begin
            mMode = 2;
            mBad  = 0;
          end
        end else begin
          mExpIdx = (posOf(d) + 1) % 31;
          mMatch  = 0;
        end
      end else begin
        if (d == seqTab[mExpIdx]) begin
          mBad = 0;
        end else begin
          mErr = 1;
          if (mCnt < CNT_MAX) mCnt = mCnt + 1;
          mBad = mBad + 1;
          if (mBad == UNLOCK_ERRS) mMode = 0;
        end
        mExpIdx = (mExpIdx + 1) % 31;
      end
    end
    if (clr) mCnt = 0;
  endtask

  task automatic applyStimulus(input bit v, input logic [4:0] d, input bit clr);
    validIn  = v;
    dataIn   = d;
    clearCnt = clr;
    modelStep(v, int'(d), clr);
    @(posedge clk);
    #1;
    checkOutput("error", 32'(error), 32'(mErr));
    checkOutput("zero_det", 32'(zeroDet), 32'(mZero));
    checkOutput("locked", 32'(locked), 32'(mMode == 2));
    checkOutput("err_cnt", 32'(errCnt), 32'(mCnt));
    validIn  = 1'b0;
    clearCnt = 1'b0;
  endtask

  task automatic sendGood();
    applyStimulus(1'b1, 5'(seqTab[genIdx]), 1'b0);
    genIdx = (genIdx + 1) % 31;
  endtask

  task automatic sendBad();
    applyStimulus(1'b1, 5'(seqTab[(genIdx + 7) % 31]), 1'b0);
    genIdx = (genIdx + 1) % 31;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput("rst_locked", 32'(locked), 32'd0);
    checkOutput("rst_error", 32'(error), 32'd0);
    checkOutput("rst_zero_det", 32'(zeroDet), 32'd0);
    checkOutput("rst_err_cnt", 32'(errCnt), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    genIdx = 0;
  endtask

  initial begin
    int s;
    int r;
    nChecks  = 0;
    nFails   = 0;
    rst      = 1'b0;
    validIn  = 1'b0;
    dataIn   = 5'd0;
    clearCnt = 1'b0;
    s = 1;
    for (int i = 0; i < 31; i++) begin
      seqTab[i] = s;
      s = ((s << 1) & 31) | (((s >> 4) ^ (s >> 2)) & 1);
    end
    modelReset();
    doReset();

    // Initial lock on 00001,00010,00100,01001.
    for (int i = 0; i < 4; i++) sendGood();
    checkOutput("lock_after_4", 32'(locked), 32'd1);
    // One full period while locked; next expected word is 10010.
    for (int i = 0; i < 31; i++) sendGood();
    checkOutput("period_cnt", 32'(errCnt), 32'd0);
    checkOutput("period_next", 32'(seqTab[genIdx]), 32'd18);

    // Single corrupted word replaced by 11111.
    applyStimulus(1'b1, 5'b11111, 1'b0);
    genIdx = (genIdx + 1) % 31;
    checkOutput("inject_error", 32'(error), 32'd1);
    checkOutput("inject_cnt", 32'(errCnt), 32'd1);
    for (int i = 0; i < 5; i++) sendGood();
    checkOutput("inject_locked", 32'(locked), 32'd1);

    // Four consecutive wrong words drop lock, then re-lock.
    for (int i = 0; i < 4; i++) sendBad();
    checkOutput("unlock_locked", 32'(locked), 32'd0);
    checkOutput("unlock_cnt", 32'(errCnt), 32'd5);
    for (int i = 0; i < 1 + LOCK_COUNT; i++) sendGood();
    checkOutput("relock", 32'(locked), 32'd1);

    // Lock achieved across idle gaps.
    doReset();
    for (int i = 0; i < 4; i++) begin
      sendGood();
      for (int g = 0; g < 5; g++) applyStimulus(1'b0, 5'($urandom_range(0, 31)), 1'b0);
    end
    checkOutput("gap_lock", 32'(locked), 32'd1);

    // Zero word while searching.
    doReset();
    applyStimulus(1'b1, 5'd0, 1'b0);
    checkOutput("search_zero", 32'(zeroDet), 32'd1);

    // Randomized traffic: good words, corruptions, zeros, gaps, resyncs, clears.
    genIdx = $urandom_range(0, 30);
    for (int i = 0; i < 2000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 15) begin
        applyStimulus(1'b0, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 49) == 0));
      end else if (r < 25) begin
        applyStimulus(1'b1, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 49) == 0));
        genIdx = (genIdx + 1) % 31;
      end else if (r < 28) begin
        applyStimulus(1'b1, 5'd0, 1'b0);
        genIdx = (genIdx + 1) % 31;
      end else begin
        if (r < 30) genIdx = $urandom_range(0, 30);
        applyStimulus(1'b1, 5'(seqTab[genIdx]), 1'($urandom_range(0, 49) == 0));
        genIdx = (genIdx + 1) % 31;
      end
    end

    // Saturation of the error counter.
    doReset();
    for (int i = 0; i < 4; i++) sendGood();
    for (int i = 0; i < 100; i++) begin
      sendBad();
      sendBad();
      sendBad();
      sendGood();
    end
    checkOutput("sat_value", 32'(errCnt), 32'(CNT_MAX));
    sendBad();
    checkOutput("sat_hold", 32'(errCnt), 32'(CNT_MAX));
    applyStimulus(1'b1, 5'(seqTab[(genIdx + 7) % 31]), 1'b1);
    genIdx = (genIdx + 1) % 31;
    checkOutput("clear_wins", 32'(errCnt), 32'd0);
    sendGood();
    sendBad();

    // Asynchronous reset in the middle of LOCKED with a nonzero count.
    checkOutput("pre_rst_locked", 32'(locked), 32'd1);
    checkOutput("pre_rst_cnt", 32'(errCnt), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_locked", 32'(locked), 32'd0);
    checkOutput("async_err_cnt", 32'(errCnt), 32'd0);
    checkOutput("async_error", 32'(error), 32'd0);
    modelReset();
    @(negedge clk);
    rst = 1'b0;
    genIdx = 3;
    for (int i = 0; i < 4; i++) sendGood();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
